// File: rtl/rf_dump_reader.sv
// Debug read-out engine: walks a wrapping register-file range through one
// read port and streams {addr,data} words to a valid/ready trace sink.
module rf_dump_reader #(
   parameter int N_ELEMENTS = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] first_addr,
   input  logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] rf_addr,
   input  logic [DATA_WIDTH-1:0] rf_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  done
);

   localparam logic [ADDR_WIDTH:0]   N_CNT     = (ADDR_WIDTH+1)'(N_ELEMENTS);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_ELEMENTS - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      SEND,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [ADDR_WIDTH-1:0] cur, cur_nx, cur_inc, start_cur;
   logic [ADDR_WIDTH:0]   rem, rem_nx, start_rem;
   logic [ADDR_WIDTH-1:0] rf_addr_nx, out_addr_nx;
   logic [DATA_WIDTH-1:0] out_data_nx;
   logic                  out_valid_nx;

   // Out-of-range start address restarts at 0; length never exceeds the file
   assign start_cur = ({1'b0, first_addr} >= N_CNT) ? '0 : first_addr;
   assign start_rem = (count > N_CNT) ? N_CNT : count;
   assign cur_inc   = (cur == LAST_ADDR) ? '0 : cur + 1'b1;

   always_comb begin
      state_nx     = state;
      cur_nx       = cur;
      rem_nx       = rem;
      rf_addr_nx   = rf_addr;
      out_valid_nx = out_valid;
      out_addr_nx  = out_addr;
      out_data_nx  = out_data;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               cur_nx     = start_cur;
               rem_nx     = start_rem;
               rf_addr_nx = start_cur;
               state_nx   = (start_rem == '0) ? DONE : READ;
            end
         end
         READ: begin
            out_data_nx  = rf_data;
            out_addr_nx  = cur;
            out_valid_nx = 1'b1;
            state_nx     = SEND;
         end
         SEND: begin
            if (out_ready) begin
               out_valid_nx = 1'b0;
               if (rem == 1) begin
                  state_nx = DONE;
               end else begin
                  cur_nx     = cur_inc;
                  rem_nx     = rem - 1'b1;
                  rf_addr_nx = cur_inc;
                  state_nx   = READ;
               end
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // A word handed over alongside abort still counts as delivered
      if (abort && state != IDLE) begin
         state_nx     = IDLE;
         out_valid_nx = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur       <= '0;
         rem       <= '0;
         rf_addr   <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         cur       <= cur_nx;
         rem       <= rem_nx;
         rf_addr   <= rf_addr_nx;
         out_valid <= out_valid_nx;
         out_addr  <= out_addr_nx;
         out_data  <= out_data_nx;
         busy      <= (state_nx != IDLE);
         done      <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: range walk, wrap, clamp, backpressure,
// abort/reset, start-while-busy and read-port coherency.
module tb_rf_dump_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [2:0]  first_addr = '0;
   logic [3:0]  count = '0;
   logic        busy;
   logic [2:0]  rf_addr;
   logic [15:0] rf_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [2:0]  out_addr;
   logic [15:0] out_data;
   logic        done;

   logic        start6 = 1'b0;
   logic        abort6 = 1'b0;
   logic [2:0]  first6 = '0;
   logic [3:0]  count6 = '0;
   logic        busy6;
   logic [2:0]  rf_addr6;
   logic [15:0] rf_data6;
   logic        out_valid6;
   logic        ready6 = 1'b1;
   logic [2:0]  out_addr6;
   logic [15:0] out_data6;
   logic        done6;

   logic [15:0] rf [8];
   assign rf_data  = rf[rf_addr];
   assign rf_data6 = rf[rf_addr6];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int t_start = 0;

   logic [2:0]  q_addr [$];
   logic [15:0] q_data [$];
   int          q_cyc [$];
   logic [2:0]  q6_addr [$];
   int valid_cnt = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;

   rf_dump_reader dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .first_addr(first_addr), .count(count), .busy(busy),
      .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
      .done(done)
   );

   rf_dump_reader #(.N_ELEMENTS(6)) dut6 (
      .clk(clk), .rst(rst), .start(start6), .abort(abort6),
      .first_addr(first6), .count(count6), .busy(busy6),
      .rf_addr(rf_addr6), .rf_data(rf_data6), .out_valid(out_valid6),
      .out_ready(ready6), .out_addr(out_addr6), .out_data(out_data6),
      .done(done6)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         q_addr.push_back(out_addr);
         q_data.push_back(out_data);
         q_cyc.push_back(cyc);
      end
      if (out_valid) valid_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (out_valid6 && ready6) q6_addr.push_back(out_addr6);
   end

   task automatic go(input logic [2:0] f, input logic [3:0] c);
      @(posedge clk); #1;
      first_addr = f;
      count = c;
      start = 1'b1;
      t_start = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, rf_addr, out_valid, out_addr, out_data, done} !== '0) begin
         bad++;
         $display("FAIL reset: got b%0b a%0h v%0b oa%0h od%0h d%0b want all 0",
                  busy, rf_addr, out_valid, out_addr, out_data, done);
      end
   endtask

   task automatic test_full();
      int b, db;
      bit ok;
      b = q_addr.size();
      db = done_cnt;
      go(3'd0, 4'd8);
      wait_idle(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL full_timeout: busy stuck"); end
      total++;
      if (q_addr.size() - b != 8) begin
         bad++;
         $display("FAIL full_count: got %0d want 8", q_addr.size() - b);
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (q_addr[b+i] !== 3'(i) || q_data[b+i] !== 16'h1000 + 16'(i) ||
                q_cyc[b+i] != t_start + 2 + 2*i) begin
               bad++;
               $display("FAIL full_word%0d: got a%0h d%0h c%0d want a%0h d%0h c%0d",
                        i, q_addr[b+i], q_data[b+i], q_cyc[b+i] - t_start,
                        i, 16'h1000 + 16'(i), 2 + 2*i);
            end
         end
      end
      total++;
      if (done_cnt - db != 1 || done_cyc != t_start + 17) begin
         bad++;
         $display("FAIL full_done: got n%0d c%0d want n1 c17",
                  done_cnt - db, done_cyc - t_start);
      end
   endtask

   task automatic test_wrap();
      int b;
      bit ok;
      logic [2:0] exp_a [4];
      exp_a = '{3'd6, 3'd7, 3'd0, 3'd1};
      b = q_addr.size();
      go(3'd6, 4'd4);
      wait_idle(ok);
      total++;
      if (!ok || q_addr.size() - b != 4) begin
         bad++;
         $display("FAIL wrap_count: got %0d want 4", q_addr.size() - b);
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (q_addr[b+i] !== exp_a[i] ||
                q_data[b+i] !== 16'h1000 + 16'(exp_a[i])) begin
               bad++;
               $display("FAIL wrap_word%0d: got a%0h d%0h want a%0h",
                        i, q_addr[b+i], q_data[b+i], exp_a[i]);
            end
         end
      end
      b = q_addr.size();
      go(3'd3, 4'd12);
      wait_idle(ok);
      total++;
      if (!ok || q_addr.size() - b != 8) begin
         bad++;
         $display("FAIL clamp_count: got %0d want 8", q_addr.size() - b);
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (q_addr[b+i] !== 3'((3 + i) % 8)) begin
               bad++;
               $display("FAIL clamp_word%0d: got a%0h want a%0h",
                        i, q_addr[b+i], (3 + i) % 8);
            end
         end
      end
   endtask

   task automatic test_n6();
      int b;
      logic [2:0] exp_a [6];
      b = q6_addr.size();
      @(posedge clk); #1;
      first6 = 3'd7; count6 = 4'd3; start6 = 1'b1;
      @(posedge clk); #1;
      start6 = 1'b0;
      for (int i = 0; i < 40 && busy6; i++) @(posedge clk);
      total++;
      if (q6_addr.size() - b != 3) begin
         bad++;
         $display("FAIL n6_oob_count: got %0d want 3", q6_addr.size() - b);
      end else begin
         total++;
         if (q6_addr[b] !== 3'd0 || q6_addr[b+1] !== 3'd1 || q6_addr[b+2] !== 3'd2) begin
            bad++;
            $display("FAIL n6_oob_addr: got %0h %0h %0h want 0 1 2",
                     q6_addr[b], q6_addr[b+1], q6_addr[b+2]);
         end
      end
      exp_a = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
      b = q6_addr.size();
      @(posedge clk); #1;
      first6 = 3'd4; count6 = 4'd15; start6 = 1'b1;
      @(posedge clk); #1;
      start6 = 1'b0;
      for (int i = 0; i < 60 && busy6; i++) @(posedge clk);
      total++;
      if (q6_addr.size() - b != 6) begin
         bad++;
         $display("FAIL n6_clamp_count: got %0d want 6", q6_addr.size() - b);
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (q6_addr[b+i] !== exp_a[i]) begin
               bad++;
               $display("FAIL n6_wrap_word%0d: got %0h want %0h",
                        i, q6_addr[b+i], exp_a[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int b, db;
      bit ok, found;
      b = q_addr.size();
      db = done_cnt;
      go(3'd0, 4'd4);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid && out_addr == 3'd2) begin
            found = 1'b1;
            break;
         end
      end
      out_ready = 1'b0;
      total++;
      if (!found) begin bad++; $display("FAIL bp_find: word 2 never valid"); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_addr !== 3'd2 || out_data !== 16'h1002) begin
            bad++;
            $display("FAIL bp_hold%0d: got v%0b a%0h d%0h want v1 a2 d1002",
                     k, out_valid, out_addr, out_data);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_idle(ok);
      total++;
      if (!ok || q_addr.size() - b != 4) begin
         bad++;
         $display("FAIL bp_count: got %0d want 4", q_addr.size() - b);
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (q_addr[b+i] !== 3'(i) || q_data[b+i] !== 16'h1000 + 16'(i)) begin
               bad++;
               $display("FAIL bp_word%0d: got a%0h d%0h want a%0h",
                        i, q_addr[b+i], q_data[b+i], i);
            end
         end
         total++;
         if (done_cnt - db != 1 || done_cyc != q_cyc[b+3] + 1) begin
            bad++;
            $display("FAIL bp_done: got n%0d c%0d want n1 c%0d",
                     done_cnt - db, done_cyc, q_cyc[b+3] + 1);
         end
      end
   endtask

   task automatic test_count0();
      int vb, bb, db;
      bit ok;
      vb = valid_cnt;
      bb = busy_cnt;
      db = done_cnt;
      go(3'd3, 4'd0);
      wait_idle(ok);
      repeat (2) @(negedge clk);
      total++;
      if (!ok || done_cnt - db != 1 || done_cyc != t_start + 1) begin
         bad++;
         $display("FAIL c0_done: got n%0d c%0d want n1 c1",
                  done_cnt - db, done_cyc - t_start);
      end
      total++;
      if (valid_cnt != vb || busy_cnt - bb != 1) begin
         bad++;
         $display("FAIL c0_flags: got valid%0d busy%0d want valid0 busy1",
                  valid_cnt - vb, busy_cnt - bb);
      end
   endtask

   task automatic check_restart(input string tag);
      int b;
      bit ok;
      b = q_addr.size();
      go(3'd2, 4'd2);
      wait_idle(ok);
      total++;
      if (!ok || q_addr.size() - b != 2) begin
         bad++;
         $display("FAIL %s_restart_count: got %0d want 2", tag, q_addr.size() - b);
      end else begin
         total++;
         if (q_addr[b] !== 3'd2 || q_addr[b+1] !== 3'd3 ||
             q_data[b] !== 16'h1002 || q_data[b+1] !== 16'h1003) begin
            bad++;
            $display("FAIL %s_restart_words: got %0h/%0h %0h/%0h want 2/1002 3/1003",
                     tag, q_addr[b], q_data[b], q_addr[b+1], q_data[b+1]);
         end
      end
   endtask

   task automatic test_abort();
      int b, db;
      b = q_addr.size();
      db = done_cnt;
      go(3'd0, 4'd8);
      for (int i = 0; i < 40 && q_addr.size() - b < 3; i++) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_next: got b%0b v%0b d%0b want 0 0 0",
                  busy, out_valid, done);
      end
      repeat (4) @(negedge clk);
      total++;
      if (done_cnt != db || q_addr.size() - b != 3) begin
         bad++;
         $display("FAIL abort_after: got done%0d words%0d want done0 words3",
                  done_cnt - db, q_addr.size() - b);
      end
      check_restart("abort");
   endtask

   task automatic test_rst_mid();
      int b, db;
      b = q_addr.size();
      db = done_cnt;
      go(3'd0, 4'd8);
      for (int i = 0; i < 40 && q_addr.size() - b < 3; i++) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, out_valid, done, rf_addr, out_addr, out_data} !== '0) begin
         bad++;
         $display("FAIL rst_next: got b%0b v%0b d%0b a%0h oa%0h od%0h want all 0",
                  busy, out_valid, done, rf_addr, out_addr, out_data);
      end
      repeat (4) @(negedge clk);
      total++;
      if (done_cnt != db || q_addr.size() - b != 3) begin
         bad++;
         $display("FAIL rst_after: got done%0d words%0d want done0 words3",
                  done_cnt - db, q_addr.size() - b);
      end
      check_restart("rst");
   endtask

   task automatic test_start_busy();
      int b;
      bit ok;
      b = q_addr.size();
      go(3'd0, 4'd3);
      @(posedge clk); #1;
      first_addr = 3'd5;
      count = 4'd8;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(ok);
      repeat (3) @(negedge clk);
      total++;
      if (!ok || busy !== 1'b0 || q_addr.size() - b != 3) begin
         bad++;
         $display("FAIL sbusy_count: got words%0d busy%0b want words3 busy0",
                  q_addr.size() - b, busy);
      end else begin
         total++;
         if (q_addr[b] !== 3'd0 || q_addr[b+1] !== 3'd1 || q_addr[b+2] !== 3'd2) begin
            bad++;
            $display("FAIL sbusy_addr: got %0h %0h %0h want 0 1 2",
                     q_addr[b], q_addr[b+1], q_addr[b+2]);
         end
      end
   endtask

   task automatic test_coherency();
      int b;
      bit ok;
      b = q_addr.size();
      go(3'd4, 4'd2);
      repeat (2) @(posedge clk);
      #1 rf[5] = 16'hBEEF;
      wait_idle(ok);
      total++;
      if (!ok || q_addr.size() - b != 2 || q_data[b+1] !== 16'hBEEF) begin
         bad++;
         $display("FAIL coh_before: got %0h want beef",
                  (q_addr.size() - b == 2) ? q_data[b+1] : 16'h0);
      end
      rf[5] = 16'h1005;
      b = q_addr.size();
      go(3'd4, 4'd2);
      repeat (3) @(posedge clk);
      #1 rf[5] = 16'hDEAD;
      wait_idle(ok);
      total++;
      if (!ok || q_addr.size() - b != 2 || q_data[b+1] !== 16'h1005) begin
         bad++;
         $display("FAIL coh_after: got %0h want 1005",
                  (q_addr.size() - b == 2) ? q_data[b+1] : 16'h0);
      end
      rf[5] = 16'h1005;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
      test_reset();
      test_full();
      test_wrap();
      test_n6();
      test_backpressure();
      test_count0();
      test_abort();
      test_rst_mid();
      test_start_busy();
      test_coherency();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
